logic_basic_debouncer: RTL and testbench



---
 rtl/logic_basic_debouncer_pkg.sv | 11 +
 rtl/logic_basic_debouncer_channel.sv | 47 ++++
 rtl/logic_basic_debouncer.sv | 31 +++
 tb/tb_logic_basic_debouncer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_basic_debouncer_pkg.sv
// Shared helpers for the debouncer slice.
package logic_basic_debouncer_pkg;

  // Counter width able to hold 0..count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned count);
    int unsigned w;
    w = $clog2(count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/logic_basic_debouncer_channel.sv
// One debounced channel: stability counter, registered level and edge pulses.
module logic_basic_debouncer_channel
  import logic_basic_debouncer_pkg::*;
#(
  parameter int unsigned COUNT       = 4,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic aclk,
  input  logic areset,
  input  logic tick,
  input  logic i,
  output logic o,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = cnt_width(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge aclk) begin
    if (areset) begin
      o    <= RESET_VALUE;
      rise <= 1'b0;
      fall <= 1'b0;
      cnt  <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (i == o) begin
        cnt <= '0;
      end else if (tick) begin
        // Accept on the COUNT-th qualified differing edge; counter never reaches COUNT.
        if (cnt == LAST) begin
          o    <= i;
          cnt  <= '0;
          rise <= i;
          fall <= ~i;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/logic_basic_debouncer.sv
// WIDTH independent debounce/edge-detect channels sharing clock, reset and tick.
module logic_basic_debouncer #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      COUNT       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             tick,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic_basic_debouncer_channel #(
      .COUNT       (COUNT),
      .RESET_VALUE (RESET_VALUE[g])
    ) u_ch (
      .aclk   (aclk),
      .areset (areset),
      .tick   (tick),
      .i      (i[g]),
      .o      (o[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

endmodule

// File: tb/tb_logic_basic_debouncer.sv
// Directed bench for logic_basic_debouncer across several parameterizations.
module tb_logic_basic_debouncer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset;

  // a: WIDTH=2 COUNT=4 RESET_VALUE=2'b10
  logic       tick_a;
  logic [1:0] i_a, o_a, rise_a, fall_a;
  // b: WIDTH=1 COUNT=3
  logic       tick_b;
  logic [0:0] i_b, o_b, rise_b, fall_b;
  // c: WIDTH=1 COUNT=8
  logic       tick_c;
  logic [0:0] i_c, o_c, rise_c, fall_c;
  // d: WIDTH=2 COUNT=1
  logic       tick_d;
  logic [1:0] i_d, o_d, rise_d, fall_d;

  int checks = 0;
  int fails  = 0;

  logic_basic_debouncer #(.WIDTH(2), .COUNT(4), .RESET_VALUE(2'b10)) dut_a (
    .aclk(clk), .areset(areset), .tick(tick_a), .i(i_a), .o(o_a), .rise(rise_a), .fall(fall_a));
  logic_basic_debouncer #(.WIDTH(1), .COUNT(3), .RESET_VALUE(1'b0)) dut_b (
    .aclk(clk), .areset(areset), .tick(tick_b), .i(i_b), .o(o_b), .rise(rise_b), .fall(fall_b));
  logic_basic_debouncer #(.WIDTH(1), .COUNT(8), .RESET_VALUE(1'b0)) dut_c (
    .aclk(clk), .areset(areset), .tick(tick_c), .i(i_c), .o(o_c), .rise(rise_c), .fall(fall_c));
  logic_basic_debouncer #(.WIDTH(2), .COUNT(1), .RESET_VALUE(2'b00)) dut_d (
    .aclk(clk), .areset(areset), .tick(tick_d), .i(i_d), .o(o_d), .rise(rise_d), .fall(fall_d));

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      i_a = (k[0]) ? 2'b01 : 2'b10;
      i_b = k[0];
      step();
      checks++;
      if (o_a !== 2'b10) begin
        fails++; $display("FAIL reset_o k=%0d got=%b exp=10", k, o_a);
      end
      checks++;
      if (rise_a !== 2'b00 || fall_a !== 2'b00) begin
        fails++; $display("FAIL reset_pulses k=%0d rise=%b fall=%b exp=00/00", k, rise_a, fall_a);
      end
    end
    checks++;
    if (o_b !== 1'b0 || o_c !== 1'b0 || o_d !== 2'b00) begin
      fails++; $display("FAIL reset_others got b=%b c=%b d=%b exp=0/0/00", o_b, o_c, o_d);
    end
    i_a = 2'b10; i_b = 1'b0;
    areset = 1'b0;
    step();
    checks++;
    if (o_a !== 2'b10 || rise_a !== 2'b00 || fall_a !== 2'b00) begin
      fails++; $display("FAIL reset_release o=%b rise=%b fall=%b exp=10/00/00", o_a, rise_a, fall_a);
    end
  endtask

  task automatic test_clean_edge();
    i_a = 2'b11;
    for (int unsigned k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (o_a[0] !== (k >= 4) || rise_a[0] !== (k == 4) || fall_a !== 2'b00) begin
        fails++; $display("FAIL clean_rise edge=%0d o=%b rise=%b fall=%b exp_o0=%0d exp_rise0=%0d",
                          k, o_a, rise_a, fall_a, (k >= 4), (k == 4));
      end
    end
    i_a = 2'b10;
    for (int unsigned k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (o_a[0] !== (k < 4) || fall_a[0] !== (k == 4) || rise_a !== 2'b00) begin
        fails++; $display("FAIL clean_fall edge=%0d o=%b rise=%b fall=%b exp_o0=%0d exp_fall0=%0d",
                          k, o_a, rise_a, fall_a, (k < 4), (k == 4));
      end
    end
  endtask

  task automatic test_glitch();
    i_a = 2'b11;
    for (int unsigned k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (o_a[0] !== 1'b0 || rise_a[0] !== 1'b0) begin
        fails++; $display("FAIL glitch_burst edge=%0d o=%b rise=%b exp o0=0 rise0=0", k, o_a, rise_a);
      end
    end
    i_a = 2'b10;
    step();
    checks++;
    if (o_a[0] !== 1'b0 || rise_a[0] !== 1'b0) begin
      fails++; $display("FAIL glitch_gap o=%b rise=%b exp o0=0 rise0=0", o_a, rise_a);
    end
    i_a = 2'b11;
    for (int unsigned k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (o_a[0] !== (k >= 4) || rise_a[0] !== (k == 4)) begin
        fails++; $display("FAIL glitch_requalify edge=%0d o=%b rise=%b exp_o0=%0d exp_rise0=%0d",
                          k, o_a, rise_a, (k >= 4), (k == 4));
      end
    end
  endtask

  task automatic test_tick_gating();
    // {i, tick, exp_o, exp_fall}: count restarts when i briefly matches o between ticks.
    logic [3:0] vec [9];
    vec = '{4'b0110, 4'b0010, 4'b1010, 4'b0110, 4'b0010,
            4'b0110, 4'b0010, 4'b0101, 4'b0000};
    i_b = 1'b1;
    for (int unsigned c = 0; c < 13; c++) begin
      tick_b = (c % 4 == 3);
      step();
      checks++;
      if (o_b !== (c >= 11) || rise_b !== (c == 11)) begin
        fails++; $display("FAIL tick_rise cycle=%0d o=%b rise=%b exp_o=%0d exp_rise=%0d",
                          c, o_b, rise_b, (c >= 11), (c == 11));
      end
    end
    for (int unsigned k = 0; k < 9; k++) begin
      i_b    = vec[k][3];
      tick_b = vec[k][2];
      step();
      checks++;
      if (o_b !== vec[k][1] || fall_b !== vec[k][0] || rise_b !== 1'b0) begin
        fails++; $display("FAIL tick_fall step=%0d o=%b fall=%b rise=%b exp_o=%b exp_fall=%b",
                          k, o_b, fall_b, rise_b, vec[k][1], vec[k][0]);
      end
    end
    tick_b = 1'b0;
  endtask

  task automatic test_mid_reset();
    tick_c = 1'b1;
    i_c = 1'b1;
    for (int unsigned k = 1; k <= 6; k++) step();
    checks++;
    if (o_c !== 1'b0 || rise_c !== 1'b0) begin
      fails++; $display("FAIL midreset_pre o=%b rise=%b exp=0/0", o_c, rise_c);
    end
    areset = 1'b1;
    step();
    areset = 1'b0;
    checks++;
    if (o_c !== 1'b0 || rise_c !== 1'b0) begin
      fails++; $display("FAIL midreset_during o=%b rise=%b exp=0/0", o_c, rise_c);
    end
    for (int unsigned k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (o_c !== (k >= 8) || rise_c !== (k == 8)) begin
        fails++; $display("FAIL midreset_after edge=%0d o=%b rise=%b exp_o=%0d exp_rise=%0d",
                          k, o_c, rise_c, (k >= 8), (k == 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [10];
    logic [1:0] prev;
    logic [1:0] exp_rise, exp_fall;
    seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01};
    tick_d = 1'b1;
    prev = 2'b00;
    for (int unsigned k = 0; k < 10; k++) begin
      i_d = seq[k];
      exp_rise = seq[k] & ~prev;
      exp_fall = ~seq[k] & prev;
      step();
      checks++;
      if (o_d !== seq[k] || rise_d !== exp_rise || fall_d !== exp_fall) begin
        fails++; $display("FAIL b2b step=%0d o=%b rise=%b fall=%b exp o=%b rise=%b fall=%b",
                          k, o_d, rise_d, fall_d, seq[k], exp_rise, exp_fall);
      end
      checks++;
      if ((rise_d & fall_d) !== 2'b00) begin
        fails++; $display("FAIL b2b_exclusive step=%0d rise=%b fall=%b exp overlap=00", k, rise_d, fall_d);
      end
      prev = seq[k];
    end
    i_d = seq[9];
    step();
    checks++;
    if (o_d !== seq[9] || rise_d !== 2'b00 || fall_d !== 2'b00) begin
      fails++; $display("FAIL b2b_hold o=%b rise=%b fall=%b exp o=%b 00/00", o_d, rise_d, fall_d, seq[9]);
    end
  endtask

  initial begin
    areset = 1'b0;
    tick_a = 1'b1; tick_b = 1'b0; tick_c = 1'b1; tick_d = 1'b1;
    i_a = 2'b10; i_b = 1'b0; i_c = 1'b0; i_d = 2'b00;
    #1;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_tick_gating();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
